// File: rtl/eth_header_fifo.sv
// First-word-fall-through FIFO of Ethernet header fields (src MAC, dest MAC, EtherType).
// Optional per-entry VLAN tag storage is compiled in with `define ETH_HEADER_FIFO_VLAN_EN.
module eth_header_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [47:0]              s_src_mac,
    input  logic [47:0]              s_dest_mac,
    input  logic [15:0]              s_type,
`ifdef ETH_HEADER_FIFO_VLAN_EN
    input  logic                     s_vlan_valid,
    input  logic [15:0]              s_vlan_tci,
    output logic                     m_vlan_valid,
    output logic [15:0]              m_vlan_tci,
`endif
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [47:0]              m_src_mac,
    output logic [47:0]              m_dest_mac,
    output logic [15:0]              m_type,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    typedef struct packed {
`ifdef ETH_HEADER_FIFO_VLAN_EN
        logic        vlan_valid;
        logic [15:0] vlan_tci;
`endif
        logic [47:0] src_mac;
        logic [47:0] dest_mac;
        logic [15:0] etype;
    } hdr_t;

    hdr_t            mem [DEPTH];
    hdr_t            wr_hdr;
    hdr_t            head;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic            push;
    logic            pop;

    // Handshake: a header moves on a rising edge only when valid and ready are
    // both high on that side; ready never depends on the opposite side's ready,
    // and flush discards any transfer offered in its cycle.
    assign s_ready = (count != FULL_COUNT);
    assign m_valid = (count != '0);
    assign push    = s_valid && s_ready && !flush;
    assign pop     = m_valid && m_ready && !flush;

    always_comb begin
        wr_hdr          = '0;
        wr_hdr.src_mac  = s_src_mac;
        wr_hdr.dest_mac = s_dest_mac;
        wr_hdr.etype    = s_type;
`ifdef ETH_HEADER_FIFO_VLAN_EN
        wr_hdr.vlan_valid = s_vlan_valid;
        wr_hdr.vlan_tci   = s_vlan_tci;
`endif
    end

    // Storage is not reset; occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_hdr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Gating on m_valid makes the outputs zero as soon as reset clears count.
    assign head       = m_valid ? mem[rd_ptr] : '0;
    assign m_src_mac  = head.src_mac;
    assign m_dest_mac = head.dest_mac;
    assign m_type     = head.etype;
`ifdef ETH_HEADER_FIFO_VLAN_EN
    assign m_vlan_valid = head.vlan_valid;
    assign m_vlan_tci   = head.vlan_tci;
`endif

endmodule

// File: tb/tb_eth_header_fifo.sv
// Self-checking bench for eth_header_fifo (default build, DEPTH=4) against a queue model.
module tb_eth_header_fifo;

    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic          flush;
    logic          s_valid;
    logic          s_ready;
    logic [47:0]   s_src_mac;
    logic [47:0]   s_dest_mac;
    logic [15:0]   s_type;
    logic          m_valid;
    logic          m_ready;
    logic [47:0]   m_src_mac;
    logic [47:0]   m_dest_mac;
    logic [15:0]   m_type;
    logic [2:0]    count;

    logic [111:0]  exp_q[$];
    logic [15:0]   seen_q[$];
    int            checks;
    int            errors;

    eth_header_fifo #(.DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_src_mac  (s_src_mac),
        .s_dest_mac (s_dest_mac),
        .s_type     (s_type),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_src_mac  (m_src_mac),
        .m_dest_mac (m_dest_mac),
        .m_type     (m_type),
        .count      (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [111:0] exp_head;
        exp_head = (exp_q.size() != 0) ? exp_q[0] : '0;
        chk("m_valid", 128'(m_valid), 128'(exp_q.size() != 0));
        chk("s_ready", 128'(s_ready), 128'(exp_q.size() != DEPTH));
        chk("count", 128'(count), 128'(exp_q.size()));
        chk("head", 128'({m_src_mac, m_dest_mac, m_type}), 128'(exp_head));
    endtask

    function automatic logic [111:0] rand_hdr();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        return r[111:0];
    endfunction

    // Called at a negedge: check, drive, clock, update model, return at next negedge.
    task automatic cycle(input logic sv, input logic mr, input logic fl, input logic [111:0] hdr);
        logic do_pop;
        logic do_push;
        check_outputs();
        s_valid = sv;
        m_ready = mr;
        flush   = fl;
        {s_src_mac, s_dest_mac, s_type} = hdr;
        #1;
        if (m_valid && mr && !fl) seen_q.push_back(m_type);
        do_pop  = (exp_q.size() != 0) && mr;
        do_push = sv && (exp_q.size() < DEPTH);
        @(posedge clk);
        if (fl) begin
            exp_q.delete();
        end else begin
            if (do_push) exp_q.push_back(hdr);
            if (do_pop) void'(exp_q.pop_front());
        end
        @(negedge clk);
        s_valid = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
    endtask

    initial begin
        logic [111:0] h;
        logic [111:0] first;
        int next_type;
        int budget;
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        s_valid   = 1'b0;
        m_ready   = 1'b0;
        {s_src_mac, s_dest_mac, s_type} = '0;

        // Reset state
        #1;
        chk("rst_m_valid", 128'(m_valid), 128'(0));
        chk("rst_count", 128'(count), 128'(0));
        chk("rst_head", 128'({m_src_mac, m_dest_mac, m_type}), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Single header, latency 1
        h = {48'h0011_2233_4455, 48'hFFFF_FFFF_FFFF, 16'h0800};
        cycle(1'b1, 1'b1, 1'b0, h);
        chk("single_count1", 128'(count), 128'(1));
        chk("single_head", 128'({m_src_mac, m_dest_mac, m_type}), 128'(h));
        cycle(1'b0, 1'b1, 1'b0, '0);
        chk("single_count0", 128'(count), 128'(0));

        // Fill with m_ready low; fifth push refused, head held
        first = rand_hdr();
        cycle(1'b1, 1'b0, 1'b0, first);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b0, 1'b0, rand_hdr());
            chk("fill_head_stable", 128'({m_src_mac, m_dest_mac, m_type}), 128'(first));
        end
        chk("fill_count", 128'(count), 128'(4));
        chk("fill_s_ready", 128'(s_ready), 128'(0));
        // Full FIFO refuses input even while popping
        cycle(1'b1, 1'b1, 1'b0, rand_hdr());
        chk("full_pop_count", 128'(count), 128'(3));
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, '0);

        // Wrap: ten headers, random m_ready
        seen_q.delete();
        next_type = 1;
        budget = 0;
        while ((next_type <= 10 || exp_q.size() != 0) && budget < 200) begin
            h = rand_hdr();
            h[15:0] = 16'(next_type);
            if (next_type <= 10 && s_ready) begin
                cycle(1'b1, 1'($urandom_range(0, 1)), 1'b0, h);
                next_type++;
            end else begin
                cycle(1'b0, 1'($urandom_range(0, 1)), 1'b0, '0);
            end
            chk("wrap_count_max", 128'(count <= 3'd4), 128'(1));
            budget++;
        end
        chk("wrap_drained_in_budget", 128'(budget < 200), 128'(1));
        chk("wrap_seen_size", 128'(seen_q.size()), 128'(10));
        for (int i = 0; i < seen_q.size(); i++) begin
            chk("wrap_order", 128'(seen_q[i]), 128'(i + 1));
        end

        // Simultaneous push and pop at count 2
        cycle(1'b1, 1'b0, 1'b0, rand_hdr());
        cycle(1'b1, 1'b0, 1'b0, rand_hdr());
        cycle(1'b1, 1'b1, 1'b0, rand_hdr());
        chk("simul_count", 128'(count), 128'(2));
        cycle(1'b0, 1'b1, 1'b0, '0);
        cycle(1'b0, 1'b1, 1'b0, '0);

        // Flush with s_valid high at count 3
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, rand_hdr());
        chk("pre_flush_count", 128'(count), 128'(3));
        cycle(1'b1, 1'b1, 1'b1, rand_hdr());
        chk("flush_count", 128'(count), 128'(0));
        chk("flush_m_valid", 128'(m_valid), 128'(0));
        h = rand_hdr();
        cycle(1'b1, 1'b0, 1'b0, h);
        chk("post_flush_head", 128'({m_src_mac, m_dest_mac, m_type}), 128'(h));
        cycle(1'b0, 1'b1, 1'b0, '0);

        // Async reset between edges with count 2
        cycle(1'b1, 1'b0, 1'b0, rand_hdr());
        cycle(1'b1, 1'b0, 1'b0, rand_hdr());
        chk("pre_rst_count", 128'(count), 128'(2));
        #2;
        rst = 1'b1;
        #1;
        chk("async_m_valid", 128'(m_valid), 128'(0));
        chk("async_count", 128'(count), 128'(0));
        chk("async_head", 128'({m_src_mac, m_dest_mac, m_type}), 128'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b0, 1'b0, '0);
        chk("post_rst_s_ready", 128'(s_ready), 128'(1));

        // Random traffic with occasional flush
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 40) == 0), rand_hdr());
        end
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
